serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell plus a registered borrow.
- It is the inverse-operation companion to the team's combinational full adder.
- Sits in the arithmetic datapath wherever area matters more than latency; it is controlled by a start/done handshake.

---
 rtl/serial_subtractor.sv | 187 ++++++++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor computing diff = a - b (modulo 2^WIDTH),
// least-significant bit first, one bit per clock. A single full-subtractor
// cell is time-shared across all bit positions, with the borrow carried in a
// register between cycles. A start/done handshake frames each operation.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (highest priority)
//   start      in   1      request, sampled only in IDLE or DONE
//   a          in   WIDTH  minuend, captured on an accepted start
//   b          in   WIDTH  subtrahend, captured on an accepted start
//   busy       out  1      high while bits are being produced (SHIFT)
//   done       out  1      one-cycle pulse when diff/borrow_out/overflow update
//   diff       out  WIDTH  result, held from done until the next accepted start
//   borrow_out out  1      unsigned borrow (a < b)
//   overflow   out  1      signed two's-complement overflow
//   bit_out    out  1      current serial difference bit
//   bit_valid  out  1      high in every SHIFT cycle
//
// Timing: start accepted at edge T -> bit_valid high in cycles T+1..T+WIDTH,
// done high in cycle T+WIDTH+1. Holding start high gives one result every
// WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             bit_out,
    output logic             bit_valid
);

    // Counter sized to hold WIDTH-1 exactly; it never has to reach WIDTH,
    // so a power-of-two WIDTH does not wrap early.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Full-subtractor borrow out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] count_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             overflow_q;
    logic             bit_out_q;
    logic             bit_valid_q;

    // Next-state values of the datapath for the current SHIFT cycle.
    logic             cell_d_d;
    logic             cell_br_d;
    logic [WIDTH-1:0] res_d;
    logic             ahead_bit_d;
    logic             load_bit_d;
    logic             last_d;

    assign cell_d_d  = fs_diff(a_sr_q[0], b_sr_q[0], borrow_q);
    assign cell_br_d = fs_borrow(a_sr_q[0], b_sr_q[0], borrow_q);
    assign res_d     = {cell_d_d, res_q[WIDTH-1:1]};
    assign last_d    = (count_q == LAST_CNT);

    // bit_out is registered, so it is computed one bit ahead: the next
    // position's bit uses the borrow this cycle is producing.
    assign ahead_bit_d = fs_diff(a_sr_q[1], b_sr_q[1], cell_br_d);
    // First bit of a new operation comes straight from the operand inputs.
    assign load_bit_d  = fs_diff(a[0], b[0], 1'b0);

    // Control FSM, serial datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= SHIFT;
                        a_sr_q      <= a;
                        b_sr_q      <= b;
                        a_msb_q     <= a[WIDTH-1];
                        b_msb_q     <= b[WIDTH-1];
                        borrow_q    <= 1'b0;
                        count_q     <= '0;
                        busy_q      <= 1'b1;
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= load_bit_d;
                    end else begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        bit_valid_q <= 1'b0;
                        bit_out_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    // start is deliberately ignored here: no abort, no reload.
                    a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
                    res_q    <= res_d;
                    borrow_q <= cell_br_d;
                    count_q  <= count_q + CNT_ONE;
                    if (last_d) begin
                        state_q      <= DONE;
                        busy_q       <= 1'b0;
                        bit_valid_q  <= 1'b0;
                        bit_out_q    <= 1'b0;
                        done_q       <= 1'b1;
                        diff_q       <= res_d;
                        borrow_out_q <= cell_br_d;
                        // Operands of differing sign whose result sign
                        // differs from the minuend's.
                        overflow_q   <= (a_msb_q != b_msb_q) && (cell_d_d != a_msb_q);
                    end else begin
                        state_q     <= SHIFT;
                        busy_q      <= 1'b1;
                        bit_valid_q <= 1'b1;
                        bit_out_q   <= ahead_bit_d;
                        done_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    bit_valid_q <= 1'b0;
                    bit_out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor (WIDTH = 8). Inputs change on the
// falling edge, outputs are sampled on the falling edge; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         bit_out;
    logic         bit_valid;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full operation starting from a falling edge in IDLE or DONE.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp_diff, input logic exp_bo, input logic exp_ov);
        a = av;
        b = bv;
        start = 1'b1;
        step();
        start = 1'b0;
        // Operands must have been captured; scramble the inputs.
        a = ~av;
        b = av ^ bv;
        for (int i = 0; i < W; i++) begin
            check({tag, ".bit_valid"}, 32'(bit_valid), 32'd1);
            check({tag, ".bit_out"},   32'(bit_out),   32'(exp_diff[i]));
            check({tag, ".busy"},      32'(busy),      32'd1);
            check({tag, ".done_early"}, 32'(done),     32'd0);
            step();
        end
        check({tag, ".done"},       32'(done),       32'd1);
        check({tag, ".diff"},       32'(diff),       32'(exp_diff));
        check({tag, ".borrow_out"}, 32'(borrow_out), 32'(exp_bo));
        check({tag, ".overflow"},   32'(overflow),   32'(exp_ov));
        check({tag, ".busy_done"},  32'(busy),       32'd0);
        step();
        check({tag, ".done_pulse"}, 32'(done),       32'd0);
        check({tag, ".diff_hold"},  32'(diff),       32'(exp_diff));
        check({tag, ".bo_hold"},    32'(borrow_out), 32'(exp_bo));
        check({tag, ".ov_hold"},    32'(overflow),   32'(exp_ov));
    endtask

    initial begin
        int n_done;
        int bad_busy;
        int bad_pos;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        @(negedge clk);
        step();
        rst = 1'b0;

        // Reset state.
        check("rst.busy",       32'(busy),       32'd0);
        check("rst.done",       32'(done),       32'd0);
        check("rst.diff",       32'(diff),       32'd0);
        check("rst.borrow_out", 32'(borrow_out), 32'd0);
        check("rst.overflow",   32'(overflow),   32'd0);
        check("rst.bit_out",    32'(bit_out),    32'd0);
        check("rst.bit_valid",  32'(bit_valid),  32'd0);

        // Main function, hand-computed vectors.
        do_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        do_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        do_op("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        do_op("sub_7F_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start and operand changes during SHIFT are ignored.
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= W + 5; k++) begin
            if (k == 3) begin
                a = 8'hFF;
                b = 8'h33;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                check("ign.diff", 32'(diff), 32'h0F);
                check("ign.pos",  32'(k),    32'(W + 1));
            end
            step();
        end
        check("ign.n_done", 32'(n_done), 32'd1);

        // Simultaneous rst and start: rst wins.
        a = 8'h44;
        b = 8'h22;
        start = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start.busy",      32'(busy),      32'd0);
        check("rst_start.bit_valid", 32'(bit_valid), 32'd0);
        check("rst_start.diff",      32'(diff),      32'd0);
        step();
        check("rst_start.idle", 32'(busy), 32'd0);

        // Reset during the 4th SHIFT cycle aborts the operation.
        do_op("pre_abort", 8'h0A, 8'h03, 8'h07, 1'b0, 1'b0);
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort.in_shift", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort.busy",      32'(busy),      32'd0);
        check("abort.bit_valid", 32'(bit_valid), 32'd0);
        check("abort.diff",      32'(diff),      32'd0);
        n_done = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done) n_done++;
            step();
        end
        check("abort.no_done", 32'(n_done), 32'd0);
        check("abort.diff_kept", 32'(diff), 32'd0);
        do_op("sub_09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        // start held high: one result every W+1 cycles.
        a = 8'h20;
        b = 8'h10;
        start = 1'b1;
        n_done = 0;
        bad_busy = 0;
        bad_pos = 0;
        for (int k = 1; k <= 3 * (W + 1); k++) begin
            step();
            if (busy == done) bad_busy++;
            if (done != ((k % (W + 1)) == 0)) bad_pos++;
            if (done) begin
                n_done++;
                check("held.diff", 32'(diff), 32'h10);
            end
        end
        start = 1'b0;
        check("held.n_done",   32'(n_done),   32'd3);
        check("held.busy",     32'(bad_busy), 32'd0);
        check("held.done_pos", 32'(bad_pos),  32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
